// File: rtl/mem_pkg.sv
// Shared definitions for the memory access front end: default widths and FSM state encoding.
package mem_pkg;

    localparam int MEM_DATA_W   = 32;
    localparam int MEM_ADDR_W   = 9;
    localparam int MEM_READ_LAT = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// MAR/MDR holder and request sequencer in front of a synchronous RAM with registered read.
// Control-unit handshake: level requests are sampled only in IDLE; busy is high in every other state, done pulses once.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = MEM_DATA_W,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int READ_LAT = MEM_READ_LAT
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] MDR_out,
    output logic              ram_Read,
    output logic              ram_Write,
    output logic [ADDR_W-1:0] ram_Address,
    output logic [DATA_W-1:0] ram_Mdatain,
    input  logic [DATA_W-1:0] ram_data_output
);

    localparam int CNT_W = $clog2(READ_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
                if (MDRin) mdr_d = BusMuxOut;
                // Write beats read, mirroring the RAM's own priority; the read is dropped.
                if (mem_write)     state_d = WR_ISSUE;
                else if (mem_read) state_d = RD_ISSUE;
            end
            WR_ISSUE: state_d = DONE;
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    mdr_d   = ram_data_output;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake and strobes are registered decodes of the next state, so they never see the request inputs combinationally.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rd_d   = (state_d == RD_ISSUE);
        wr_d   = (state_d == WR_ISSUE);
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_Read    = rd_q;
    assign ram_Write   = wr_q;
    assign MDR_out     = mdr_q;
    assign ram_Address = mar_q;
    assign ram_Mdatain = mdr_q;

endmodule
